// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped read-only word cache.
// Default geometry lives here so the top and the bench agree on widths.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } state_t;

    localparam logic [31:0] RAM_INIT = 32'hC0DE_0000;

    localparam int unsigned DEF_LINES        = 16;
    localparam int unsigned DEF_RAM_WORDS    = 1024;
    localparam int unsigned DEF_MISS_LATENCY = 4;

    localparam int unsigned IDX_W    = $clog2(DEF_LINES);
    localparam int unsigned TAG_W    = 32 - IDX_W;
    localparam int unsigned RAM_AW_W = $clog2(DEF_RAM_WORDS);

endpackage

// File: rtl/cache_backing_ram.sv
// Read-only backing store; word i holds RAM_INIT | i. Read data is captured on rd_en,
// rd_valid pulses MISS_LATENCY cycles later; a new rd_en restarts the countdown.
module cache_backing_ram
    import cache_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = DEF_RAM_WORDS,
    parameter int unsigned MISS_LATENCY = DEF_MISS_LATENCY
) (
    input  logic                         clk,
    input  logic                         rd_en,
    input  logic [$clog2(RAM_WORDS)-1:0] rd_addr,
    output logic [31:0]                  rd_data,
    output logic                         rd_valid
);
    localparam int unsigned CNT_W = $clog2(MISS_LATENCY + 1);

    logic [31:0]      mem [RAM_WORDS];
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Contents are fixed, so the array is a constant table rather than storage.
    for (genvar i = 0; i < int'(RAM_WORDS); i++) begin : g_init
        assign mem[i] = RAM_INIT | 32'(i);
    end

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (rd_en) begin
            data_d = mem[rd_addr];
            cnt_d  = CNT_W'(MISS_LATENCY);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        cnt_q  <= cnt_d;
    end

    assign rd_data  = data_q;
    assign rd_valid = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cache_nomode.sv
// Direct-mapped read-only word cache: a change of {address,data} issues a read.
// response is high 1 cycle on a hit, 1+MISS_LATENCY on a miss; out updates only on completion.
module cache_nomode
    import cache_pkg::*;
#(
    parameter int unsigned LINES        = DEF_LINES,
    parameter int unsigned RAM_WORDS    = DEF_RAM_WORDS,
    parameter int unsigned MISS_LATENCY = DEF_MISS_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data,
    output logic        response,
    output logic [31:0] out
);
    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 32 - IW;
    localparam int unsigned AW = $clog2(RAM_WORDS);

    state_t            state_q, state_d;
    logic              response_q, response_d;
    logic [31:0]       out_q, out_d;
    logic [31:0]       prev_addr_q, prev_addr_d;
    logic [31:0]       prev_data_q, prev_data_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TW-1:0]     tag_q  [LINES];
    logic [TW-1:0]     tag_d  [LINES];
    logic [31:0]       line_q [LINES];
    logic [31:0]       line_d [LINES];

    logic              rd_en;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     tag;
    logic              hit;

    // Lookup works on the captured request so inputs may move while busy.
    assign idx = prev_addr_q[IW-1:0];
    assign tag = prev_addr_q[31:IW];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    cache_backing_ram #(
        .RAM_WORDS    (RAM_WORDS),
        .MISS_LATENCY (MISS_LATENCY)
    ) u_ram (
        .clk      (clk),
        .rd_en    (rd_en),
        .rd_addr  (prev_addr_q[AW-1:0]),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always_comb begin
        state_d     = state_q;
        response_d  = response_q;
        out_d       = out_q;
        prev_addr_d = prev_addr_q;
        prev_data_d = prev_data_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        line_d      = line_q;
        rd_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if ({address, data} != {prev_addr_q, prev_data_q}) begin
                    prev_addr_d = address;
                    prev_data_d = data;
                    response_d  = 1'b1;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    out_d      = line_q[idx];
                    response_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    rd_en   = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (rd_valid) begin
                    valid_d[idx] = 1'b1;
                    tag_d[idx]   = tag;
                    line_d[idx]  = rd_data;
                    out_d        = rd_data;
                    response_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            response_q  <= 1'b0;
            out_q       <= '0;
            prev_addr_q <= '0;
            prev_data_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            response_q  <= response_d;
            out_q       <= out_d;
            prev_addr_q <= prev_addr_d;
            prev_data_q <= prev_data_d;
            valid_q     <= valid_d;
        end
    end

    // Line storage needs no reset; a fill interrupted by reset must not land.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q  <= tag_d;
            line_q <= line_d;
        end
    end

    assign response = response_q;
    assign out      = out_q;

endmodule

// File: tb/tb_cache_nomode.sv
// Bench for cache_nomode: directed vector table, hand-written multi-cycle corners,
// then random requests checked against a transaction-level cache model.
module tb_cache_nomode;
    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data;
    logic        response;
    logic [31:0] out;

    cache_nomode dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .data     (data),
        .response (response),
        .out      (out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit          mvalid [16];
    logic [27:0] mtag   [16];
    logic [31:0] mdata  [16];
    logic [31:0] pa, pd;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          cyc;
        logic [31:0] w;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        pa = '0;
        pd = '0;
    endtask

    // Cache behaviour from first principles: hit costs 1 cycle, miss costs 1+ML and fills.
    task automatic model_access(input logic [31:0] a, output int cyc, output logic [31:0] w);
        int ix;
        ix = int'(a[3:0]);
        if (mvalid[ix] && mtag[ix] == a[31:4]) begin
            cyc = 1;
            w   = mdata[ix];
        end else begin
            cyc        = 1 + ML;
            w          = 32'hC0DE_0000 | (a & 32'h0000_03FF);
            mvalid[ix] = 1'b1;
            mtag[ix]   = a[31:4];
            mdata[ix]  = w;
        end
    endtask

    // Called just after an edge on which new inputs were applied.
    task automatic run_busy(output int n, output bit stable);
        logic [31:0] o0;
        o0     = out;
        n      = 0;
        stable = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!response) break;
            n++;
            if (out !== o0) stable = 1'b0;
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input int cyc,
                          input logic [31:0] w, input string nm);
        int n;
        bit st;
        @(posedge clk); #1;
        address = a;
        data    = d;
        run_busy(n, st);
        chk({nm, "_cycles"}, 32'(n), 32'(cyc));
        chk({nm, "_out"}, out, w);
        chk({nm, "_stable"}, {31'd0, st}, 32'd1);
        pa = a;
        pd = d;
    endtask

    vec_t        vecs [7];
    int          n, cyc;
    bit          st, ok;
    logic [31:0] w, a, d;

    initial begin
        vecs[0] = '{32'd5,     32'd0, 5, 32'hC0DE_0005};
        vecs[1] = '{32'd5,     32'd1, 1, 32'hC0DE_0005};
        vecs[2] = '{32'd21,    32'd1, 5, 32'hC0DE_0015};
        vecs[3] = '{32'd5,     32'd1, 5, 32'hC0DE_0005};
        vecs[4] = '{32'd5,     32'd2, 1, 32'hC0DE_0005};
        vecs[5] = '{32'd0,     32'd2, 5, 32'hC0DE_0000};
        vecs[6] = '{32'd0,     32'd0, 1, 32'hC0DE_0000};

        // Reset with {0,0} held: never a request.
        reset   = 1'b1;
        address = '0;
        data    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_response", {31'd0, response}, 32'd0);
        chk("reset_out", out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (response !== 1'b0) ok = 1'b0;
        end
        chk("zero_not_request", {31'd0, ok}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            model_access(vecs[i].a, cyc, w);
            do_req(vecs[i].a, vecs[i].d, vecs[i].cyc, vecs[i].w, $sformatf("vec%0d", i));
        end

        // Aliasing address misses; an address change mid-fill follows as a second request.
        model_access(32'h405, cyc, w);
        @(posedge clk); #1;
        address = 32'h405;
        @(posedge clk);
        @(negedge clk);
        chk("alias_rise", {31'd0, response}, 32'd1);
        @(posedge clk); #1;
        address = 32'd7;
        n  = 1;
        st = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!response) break;
            n++;
        end
        chk("alias_cycles", 32'(n), 32'(cyc));
        chk("alias_out", out, 32'hC0DE_0005);
        model_access(32'd7, cyc, w);
        run_busy(n, st);
        chk("follow_cycles", 32'(n), 32'(cyc));
        chk("follow_out", out, 32'hC0DE_0007);
        chk("follow_stable", {31'd0, st}, 32'd1);
        pa = 32'd7;

        // Reset clears valid bits; a reset mid-fill aborts with out at 0.
        @(posedge clk); #1;
        reset   = 1'b1;
        address = 32'd7;
        data    = 32'd3;
        model_reset();
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_abort_busy", {31'd0, response}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("pre_abort_fill", {31'd0, response}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_response", {31'd0, response}, 32'd0);
        chk("abort_out", out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        model_access(32'd7, cyc, w);
        run_busy(n, st);
        chk("rereq_cycles", 32'(n), 32'(cyc));
        chk("rereq_out", out, 32'hC0DE_0007);
        pa = 32'd7;
        pd = 32'd3;

        // Random traffic over a small index space with occasional far tags.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = pa;
                d = pd;
            end else begin
                a = 32'($urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) a = ($urandom & 32'hFFFF_FFF0) | a;
                d = ($urandom_range(0, 1) == 0) ? pd : $urandom;
            end
            if ({a, d} == {pa, pd}) begin
                @(posedge clk); #1;
                address = a;
                data    = d;
                ok = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    if (response !== 1'b0) ok = 1'b0;
                end
                chk($sformatf("rnd%0d_noreq", i), {31'd0, ok}, 32'd1);
            end else begin
                model_access(a, cyc, w);
                do_req(a, d, cyc, w, $sformatf("rnd%0d", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
